// File: rtl/hsv_calc.sv
// RGB-to-HSV back end: turns (R, G, B, max, min, max index) into H/S/V with one shared restoring divider.
// Optional HSV_FASTGREY_EN: grey pixels (max==min) bypass both divisions and complete right after LOAD.
module hsv_calc #(
    parameter int DIV_BITS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [9:0] r,
    input  logic [9:0] g,
    input  logic [9:0] b,
    input  logic [9:0] max_val,
    input  logic [9:0] min_val,
    input  logic [1:0] max_idx,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:0] h,
    output logic [7:0] s,
    output logic [7:0] v
);

    localparam int CNT_W = (DIV_BITS > 1) ? $clog2(DIV_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIV_S,
        DIV_H,
        DONE
    } state_t;

    state_t              r_state;

    logic [7:0]          r_r;
    logic [7:0]          r_g;
    logic [7:0]          r_b;
    logic [7:0]          r_max;
    logic [7:0]          r_min;
    logic [1:0]          r_idx;

    logic [7:0]          r_delta;
    logic [7:0]          r_dmag;
    logic                r_dneg;

    logic [DIV_BITS-1:0] r_num;
    logic [7:0]          r_rem;
    logic [7:0]          r_div;
    logic [CNT_W-1:0]    r_cnt;

    logic                r_out_valid;
    logic [8:0]          r_h;
    logic [7:0]          r_s;
    logic [7:0]          r_v;

    logic [7:0]          w_delta;
    logic [8:0]          w_d;
    logic [7:0]          w_dmag;
    logic [DIV_BITS-1:0] w_num_s;
    logic [DIV_BITS-1:0] w_num_h;
    logic [8:0]          w_rem_sh;
    logic                w_ge;
    logic [7:0]          w_rem_nxt;
    logic [DIV_BITS-1:0] w_quo_nxt;
    logic                w_last;
    logic [8:0]          w_hq;
    logic [8:0]          w_h_final;
    logic                w_unused_bits;

    // Upper two bits of every channel input carry no information for 8-bit pixels.
    assign w_unused_bits = ^{r[9:8], g[9:8], b[9:8], max_val[9:8], min_val[9:8]};

    assign w_delta = r_max - r_min;

    // NOTE: always_comb gives every output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_d = '0;
        case (r_idx)
            2'd1:    w_d = {1'b0, r_b} - {1'b0, r_r};
            2'd2:    w_d = {1'b0, r_r} - {1'b0, r_g};
            default: w_d = {1'b0, r_g} - {1'b0, r_b};
        endcase
    end

    assign w_dmag  = w_d[8] ? 8'(9'd0 - w_d) : w_d[7:0];
    assign w_num_s = DIV_BITS'(w_delta) * DIV_BITS'(255);
    assign w_num_h = DIV_BITS'(r_dmag) * DIV_BITS'(60);

    // One restoring step: shift the next numerator bit into the remainder, subtract if it fits.
    assign w_rem_sh  = {r_rem, r_num[DIV_BITS-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_div});
    assign w_rem_nxt = w_ge ? 8'(w_rem_sh - {1'b0, r_div}) : w_rem_sh[7:0];
    assign w_quo_nxt = {r_num[DIV_BITS-2:0], w_ge};
    assign w_last    = (r_cnt == CNT_W'(DIV_BITS - 1));

    assign w_hq = w_quo_nxt[8:0];

    // Hue from the final quotient; a negative offset from red wraps into 0..359.
    always_comb begin
        w_h_final = '0;
        if (r_delta != 8'd0) begin
            case (r_idx)
                2'd1:    w_h_final = r_dneg ? (9'd120 - w_hq) : (9'd120 + w_hq);
                2'd2:    w_h_final = r_dneg ? (9'd240 - w_hq) : (9'd240 + w_hq);
                default: w_h_final = (r_dneg && (w_hq != 9'd0)) ? (9'd360 - w_hq) : w_hq;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_r         <= '0;
            r_g         <= '0;
            r_b         <= '0;
            r_max       <= '0;
            r_min       <= '0;
            r_idx       <= '0;
            r_delta     <= '0;
            r_dmag      <= '0;
            r_dneg      <= 1'b0;
            r_num       <= '0;
            r_rem       <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_h         <= '0;
            r_s         <= '0;
            r_v         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_r     <= r[7:0];
                        r_g     <= g[7:0];
                        r_b     <= b[7:0];
                        r_max   <= max_val[7:0];
                        r_min   <= min_val[7:0];
                        r_idx   <= max_idx;
                        r_state <= LOAD;
                    end
                end

                LOAD: begin
                    r_delta <= w_delta;
                    r_dmag  <= w_dmag;
                    r_dneg  <= w_d[8];
                    r_num   <= w_num_s;
                    r_div   <= r_max;
                    r_rem   <= '0;
                    r_cnt   <= '0;
                    r_state <= DIV_S;
`ifdef HSV_FASTGREY_EN
                    if (w_delta == 8'd0) begin
                        r_h     <= '0;
                        r_s     <= '0;
                        r_v     <= r_max;
                        r_state <= DONE;
                    end
`endif
                end

                DIV_S: begin
                    r_num <= w_quo_nxt;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_s     <= (r_max == 8'd0) ? 8'd0 : w_quo_nxt[7:0];
                        r_num   <= w_num_h;
                        r_div   <= r_delta;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_state <= DIV_H;
                    end
                end

                DIV_H: begin
                    r_num <= w_quo_nxt;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_h         <= w_h_final;
                        r_v         <= r_max;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end

                DONE: begin
                    // The fast grey path enters DONE with out_valid still low and raises it here.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign h         = r_h;
    assign s         = r_s;
    assign v         = r_v;

endmodule

// File: tb/tb_hsv_calc.sv
// Self-checking bench for hsv_calc: directed corner pixels plus randomized pixels against an arithmetic HSV model.
module tb_hsv_calc;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
    logic [9:0] max_val;
    logic [9:0] min_val;
    logic [1:0] max_idx;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] h;
    logic [7:0] s;
    logic [7:0] v;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef HSV_FASTGREY_EN
    localparam int GREY_LAT = 2;
`else
    localparam int GREY_LAT = 33;
`endif
    localparam int FULL_LAT = 33;

    always #5 clk = ~clk;

    hsv_calc dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .r         (r),
        .g         (g),
        .b         (b),
        .max_val   (max_val),
        .min_val   (min_val),
        .max_idx   (max_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .h         (h),
        .s         (s),
        .v         (v)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // HSV from first principles: integer degrees, truncating divisions, hue wrapped into 0..359.
    function automatic void model(input int rr, input int gg, input int bb, input int idx,
                                  output int eh, output int es, output int ev);
        int mx, mn, dl, d, q;
        mx = rr; if (gg > mx) mx = gg; if (bb > mx) mx = bb;
        mn = rr; if (gg < mn) mn = gg; if (bb < mn) mn = bb;
        dl = mx - mn;
        ev = mx;
        es = (mx == 0) ? 0 : (255 * dl) / mx;
        if (dl == 0) begin
            eh = 0;
        end else begin
            case (idx)
                1:       d = bb - rr;
                2:       d = rr - gg;
                default: d = gg - bb;
            endcase
            q = (((d < 0) ? -d : d) * 60) / dl;
            if (d < 0) q = -q;
            eh = ((idx == 1) ? 120 : (idx == 2) ? 240 : 0) + q;
            if (eh < 0) eh += 360;
        end
    endfunction

    // Presents a pixel (with junk in the ignored upper bits) and returns just after the accepting edge.
    task automatic send_pixel(input int rr, input int gg, input int bb, input int idx);
        int mx, mn, n;
        mx = rr; if (gg > mx) mx = gg; if (bb > mx) mx = bb;
        mn = rr; if (gg < mn) mn = gg; if (bb < mn) mn = bb;
        @(negedge clk);
        r        = {2'($urandom), 8'(rr)};
        g        = {2'($urandom), 8'(gg)};
        b        = {2'($urandom), 8'(bb)};
        max_val  = {2'($urandom), 8'(mx)};
        min_val  = {2'($urandom), 8'(mn)};
        max_idx  = 2'(idx);
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts edges after the accepting edge until out_valid is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_pixel(input string tag, input int rr, input int gg, input int bb, input int idx,
                             input int eh, input int es, input int ev);
        int lat;
        send_pixel(rr, gg, bb, idx);
        wait_valid(lat);
        check({tag, "_latency"}, lat, (rr == gg && gg == bb) ? GREY_LAT : FULL_LAT);
        check({tag, "_h"}, h, eh);
        check({tag, "_s"}, s, es);
        check({tag, "_v"}, v, ev);
        check({tag, "_in_ready_in_done"}, in_ready, 0);
        @(negedge clk);
        check({tag, "_out_valid_fell"}, out_valid, 0);
        check({tag, "_in_ready_after"}, in_ready, 1);
    endtask

    initial begin
        int eh, es, ev, lat, seen, rr, gg, bb, idx;
        int cand[$];

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        r = '0; g = '0; b = '0; max_val = '0; min_val = '0; max_idx = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_h", h, 0);
        check("reset_s", s, 0);
        check("reset_v", v, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", in_ready, 1);

        run_pixel("red",      255,   0,   0, 0,   0, 255, 255);
        run_pixel("green",      0, 255,   0, 1, 120, 255, 255);
        run_pixel("blue",       0,   0, 255, 2, 240, 255, 255);
        run_pixel("orange",   200, 100,  50, 0,  20, 191, 200);
        run_pixel("wrap",     255,   0, 128, 0, 330, 255, 255);
        run_pixel("grey",     100, 100, 100, 0,   0,   0, 100);
        run_pixel("black",      0,   0,   0, 0,   0,   0,   0);
        run_pixel("idx3",     250,  10, 100, 3, 338, 244, 250);
        run_pixel("g_neg",     90, 200,  30, 1,  99, 216, 200);
        run_pixel("b_neg",     10,  50, 180, 2, 226, 240, 180);

        // Backpressure: result must hold and new input must be ignored until the handshake.
        out_ready = 1'b0;
        send_pixel(200, 100, 50, 0);
        wait_valid(lat);
        check("bp_latency", lat, FULL_LAT);
        r = 10'd7; g = 10'd200; b = 10'd9; max_val = 10'd200; min_val = 10'd7; max_idx = 2'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_out_valid", out_valid, 1);
            check("bp_hold_h", h, 20);
            check("bp_hold_s", s, 191);
            check("bp_hold_v", v, 200);
            check("bp_hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        @(negedge clk);
        check("bp_single_result", out_valid, 0);

        // Reset in the middle of the saturation division discards the pixel.
        send_pixel(255, 0, 128, 0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready_low", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready_after", in_ready, 1);
        check("mid_rst_h_cleared", h, 0);
        check("mid_rst_v_cleared", v, 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1;
        end
        check("mid_rst_no_out_valid", seen, 0);
        run_pixel("after_rst", 200, 100, 50, 0, 20, 191, 200);

        // Random pixels, including forced ties and greys, any valid max index (3 aliases R).
        for (int i = 0; i < 24; i++) begin
            rr = $urandom_range(0, 255);
            gg = $urandom_range(0, 255);
            bb = $urandom_range(0, 255);
            case ($urandom_range(0, 5))
                0: gg = rr;
                1: begin gg = rr; bb = rr; end
                default: ;
            endcase
            cand.delete();
            if (rr >= gg && rr >= bb) cand.push_back(0);
            if (gg >= rr && gg >= bb) cand.push_back(1);
            if (bb >= rr && bb >= gg) cand.push_back(2);
            idx = cand[$urandom_range(0, cand.size() - 1)];
            if (idx == 0 && $urandom_range(0, 1) == 1) idx = 3;
            model(rr, gg, bb, idx, eh, es, ev);
            run_pixel("rand", rr, gg, bb, idx, eh, es, ev);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
